nl_tile_injection_arbiter: RTL and testbench

//  Shares one mesh-router TILE input port between NR local requesters (cores/DMA).

---
 rtl/nl_tile_injection_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_nl_tile_injection_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nl_tile_injection_arbiter.sv
// Injection arbiter sharing one router TILE input among NR requesters: round-robin packet grant,
// VC pick, head/body/tail sequencing, per-VC credits. Optional stats behind `NL_INJ_STATS_EN.
module nl_tile_injection_arbiter #(
    parameter int NR     = 4,
    parameter int NV     = 2,
    parameter int DEPTH  = 4,
    parameter int MAXLEN = 8,
    parameter int DW     = 32,
    parameter int LW     = $clog2(MAXLEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    req_valid,
    input  logic [NR*LW-1:0] req_len,
    input  logic [NR*DW-1:0] req_data,
    output logic [NR-1:0]    req_grant,
    output logic [NR-1:0]    req_ack,
    output logic             flit_valid,
    output logic             flit_head,
    output logic             flit_tail,
    output logic [NV-1:0]    flit_vc,
    output logic [DW-1:0]    flit_data,
    input  logic             credit_valid,
    input  logic [NV-1:0]    credit_vc,
    output logic             credit_err,
    output logic [1:0]       state_dbg
`ifdef NL_INJ_STATS_EN
    ,
    output logic [NR*32-1:0] pkt_count,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (NR > 1) ? $clog2(NR) : 1;

    // Handshake: req_grant is held for the whole packet; each cycle req_ack[i] is high the
    // flit presented on req_data[i] is consumed and the requester must advance to its next flit.
    // That consumed flit appears on flit_* one cycle later.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rr_q;
    logic [RW-1:0]   win_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   sent_q;
    logic [NV-1:0]   vc_q;
    logic [CW-1:0]   credit_q [NV];

    logic            pick_found;
    logic [RW-1:0]   pick_idx;
    logic [LW-1:0]   pick_len;
    logic [NV-1:0]   credit_nz;
    logic [NV-1:0]   vc_pick;
    logic            vc_found;
    logic            busy;
    logic            send_go;
    logic            last_flit;
    logic [RW-1:0]   rr_next;

    assign state_dbg = state_q;

    // Round-robin search starting at the pointer; zero-length requests are never eligible.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NR; i++) begin
            if (!pick_found && req_valid[(int'(rr_q) + i) % NR] &&
                (req_len[((int'(rr_q) + i) % NR) * LW +: LW] != '0)) begin
                pick_found = 1'b1;
                pick_idx   = RW'((int'(rr_q) + i) % NR);
            end
        end
    end

    assign pick_len = req_len[int'(pick_idx) * LW +: LW];

    always_comb begin
        vc_pick  = '0;
        vc_found = 1'b0;
        for (int v = 0; v < NV; v++) begin
            credit_nz[v] = (credit_q[v] != '0);
            if (!vc_found && credit_nz[v]) begin
                vc_found   = 1'b1;
                vc_pick[v] = 1'b1;
            end
        end
    end

    assign busy      = (state_q == S_GRANT) || (state_q == S_SEND);
    assign send_go   = busy && ((credit_nz & vc_q) != '0);
    assign last_flit = (sent_q == len_q - LW'(1));
    assign rr_next   = (win_q == RW'(NR - 1)) ? '0 : win_q + RW'(1);

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_ack[i] = send_go && (win_q == RW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found && vc_found) state_d = S_GRANT;
            end
            S_GRANT, S_SEND: begin
                if (send_go && last_flit) state_d = S_IDLE;
                else                      state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            win_q      <= '0;
            len_q      <= '0;
            sent_q     <= '0;
            vc_q       <= '0;
            req_grant  <= '0;
            flit_valid <= 1'b0;
            flit_head  <= 1'b0;
            flit_tail  <= 1'b0;
            flit_vc    <= '0;
            flit_data  <= '0;
        end else begin
            flit_valid <= 1'b0;
            flit_head  <= 1'b0;
            flit_tail  <= 1'b0;
            if (state_q == S_IDLE && state_d == S_GRANT) begin
                win_q     <= pick_idx;
                len_q     <= pick_len;
                vc_q      <= vc_pick;
                sent_q    <= '0;
                req_grant <= NR'(1) << pick_idx;
            end
            if (send_go) begin
                flit_valid <= 1'b1;
                flit_head  <= (sent_q == '0);
                flit_tail  <= last_flit;
                flit_vc    <= vc_q;
                flit_data  <= req_data[int'(win_q) * DW +: DW];
                sent_q     <= sent_q + LW'(1);
                if (last_flit) begin
                    req_grant <= '0;
                    rr_q      <= rr_next;
                end
            end
        end
    end

    // A return on a counter already at DEPTH is dropped and flagged; send+return nets to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err <= 1'b0;
            for (int v = 0; v < NV; v++) credit_q[v] <= CW'(DEPTH);
        end else begin
            for (int v = 0; v < NV; v++) begin
                if (credit_valid && credit_vc[v] && !(send_go && vc_q[v])) begin
                    if (credit_q[v] == CW'(DEPTH)) credit_err <= 1'b1;
                    else                           credit_q[v] <= credit_q[v] + CW'(1);
                end else if (send_go && vc_q[v] && !(credit_valid && credit_vc[v])) begin
                    credit_q[v] <= credit_q[v] - CW'(1);
                end
            end
        end
    end

`ifdef NL_INJ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count    <= '0;
            stall_cycles <= '0;
        end else begin
            if (send_go && last_flit) begin
                pkt_count[int'(win_q) * 32 +: 32] <= pkt_count[int'(win_q) * 32 +: 32] + 32'd1;
            end
            if (busy && !send_go) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nl_tile_injection_arbiter.sv
// Directed bench for nl_tile_injection_arbiter: grant order, flit framing, credit stall/return,
// VC fallback, credit_err and mid-packet reset, all against hand-computed values.
module tb_nl_tile_injection_arbiter;

    localparam int NR = 4;
    localparam int NV = 2;
    localparam int LW = 4;
    localparam int DW = 32;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*LW-1:0] req_len;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_grant;
    logic [NR-1:0]    req_ack;
    logic             flit_valid;
    logic             flit_head;
    logic             flit_tail;
    logic [NV-1:0]    flit_vc;
    logic [DW-1:0]    flit_data;
    logic             credit_valid;
    logic [NV-1:0]    credit_vc;
    logic             credit_err;
    logic [1:0]       state_dbg;
`ifdef NL_INJ_STATS_EN
    logic [NR*32-1:0] pkt_count;
    logic [31:0]      stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    nl_tile_injection_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_len      (req_len),
        .req_data     (req_data),
        .req_grant    (req_grant),
        .req_ack      (req_ack),
        .flit_valid   (flit_valid),
        .flit_head    (flit_head),
        .flit_tail    (flit_tail),
        .flit_vc      (flit_vc),
        .flit_data    (flit_data),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .credit_err   (credit_err),
        .state_dbg    (state_dbg)
`ifdef NL_INJ_STATS_EN
        ,
        .pkt_count    (pkt_count),
        .stall_cycles (stall_cycles)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // driver tasks
    task automatic set_req(input int i, input logic v, input logic [LW-1:0] len,
                           input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_len[i*LW +: LW]    = len;
        req_data[i*DW +: DW]   = d;
    endtask

    task automatic set_credit(input logic v, input logic [NV-1:0] vc);
        credit_valid = v;
        credit_vc    = vc;
    endtask

    // checker
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flit(input string tag, input logic h, input logic t,
                            input logic [NV-1:0] vc, input logic [DW-1:0] d);
        chk({tag, "_valid"}, flit_valid, 1'b1);
        chk({tag, "_head"},  flit_head, h);
        chk({tag, "_tail"},  flit_tail, t);
        chk({tag, "_vc"},    flit_vc, vc);
        chk({tag, "_data"},  flit_data, d);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_len   = '0;
        req_data  = '0;
        set_credit(1'b0, '0);

        // reset state
        do_reset();
        chk("rst_flit_valid", flit_valid, 1'b0);
        chk("rst_grant", req_grant, 4'b0000);
        chk("rst_ack", req_ack, 4'b0000);
        chk("rst_err", credit_err, 1'b0);
        chk("rst_state", state_dbg, 2'd0);

        // 1: req0 len=3 on full credits
        set_req(0, 1'b1, 4'd3, 32'hA000_0000);
        tick();
        chk("t1_grant", req_grant, 4'b0001);
        chk("t1_ack0", req_ack, 4'b0001);
        chk("t1_nofl", flit_valid, 1'b0);
        chk("t1_state", state_dbg, 2'd1);
        set_req(0, 1'b0, 4'd3, 32'hA000_0000);
        tick();
        chk_flit("t1_f0", 1'b1, 1'b0, 2'b01, 32'hA000_0000);
        chk("t1_ack1", req_ack, 4'b0001);
        set_req(0, 1'b0, 4'd3, 32'hA000_0001);
        tick();
        chk_flit("t1_f1", 1'b0, 1'b0, 2'b01, 32'hA000_0001);
        chk("t1_ack2", req_ack, 4'b0001);
        set_req(0, 1'b0, 4'd3, 32'hA000_0002);
        tick();
        chk_flit("t1_f2", 1'b0, 1'b1, 2'b01, 32'hA000_0002);
        chk("t1_grant_drop", req_grant, 4'b0000);
        chk("t1_ack_end", req_ack, 4'b0000);
        tick();
        chk("t1_idle_fl", flit_valid, 1'b0);

        // 2: all four requesters, len=1, continuously; fifth packet falls back to VC1
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 4'd1, 32'h100 + i);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t2_grant%0d", k), req_grant, 4'b0001 << (k % NR));
            if (k == 4) req_valid = '0;
            tick();
            chk_flit($sformatf("t2_f%0d", k), 1'b1, 1'b1, (k < 4) ? 2'b01 : 2'b10,
                     32'h100 + (k % NR));
            chk($sformatf("t2_gdrop%0d", k), req_grant, 4'b0000);
        end

        // 3: len=6 with no returns stalls after 4 flits; single credits release flits 5 and 6
        do_reset();
        set_req(0, 1'b1, 4'd6, 32'hB0);
        tick();
        chk("t3_grant", req_grant, 4'b0001);
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_flit($sformatf("t3_f%0d", k), (k == 0), 1'b0, 2'b01, 32'hB0);
        end
        chk("t3_stall_ack", req_ack, 4'b0000);
        chk("t3_stall_state", state_dbg, 2'd2);
        tick();
        chk("t3_stall_fl", flit_valid, 1'b0);
        chk("t3_stall_grant", req_grant, 4'b0001);
        set_credit(1'b1, 2'b01);
        tick();
        set_credit(1'b0, 2'b00);
        chk("t3_ack_ret1", req_ack, 4'b0001);
        tick();
        chk_flit("t3_f4", 1'b0, 1'b0, 2'b01, 32'hB0);
        chk("t3_ack_dry", req_ack, 4'b0000);
        set_credit(1'b1, 2'b01);
        tick();
        set_credit(1'b0, 2'b00);
        chk("t3_ack_ret2", req_ack, 4'b0001);
        tick();
        chk_flit("t3_f5", 1'b0, 1'b1, 2'b01, 32'hB0);
        chk("t3_grant_drop", req_grant, 4'b0000);

        // 4: VC0 exhausted, VC1 full -> req1 len=2 goes on VC1
        set_req(1, 1'b1, 4'd2, 32'hC0);
        tick();
        chk("t4_grant", req_grant, 4'b0010);
        chk("t4_ack", req_ack, 4'b0010);
        req_valid = '0;
        tick();
        chk_flit("t4_f0", 1'b1, 1'b0, 2'b10, 32'hC0);
        set_req(1, 1'b0, 4'd2, 32'hC1);
        tick();
        chk_flit("t4_f1", 1'b0, 1'b1, 2'b10, 32'hC1);

        // 5: send and return on VC0 in the same cycle, then one return at DEPTH
        do_reset();
        set_req(0, 1'b1, 4'd1, 32'hD0);
        tick();
        chk("t5_ack", req_ack, 4'b0001);
        req_valid = '0;
        set_credit(1'b1, 2'b01);
        tick();
        chk_flit("t5_f0", 1'b1, 1'b1, 2'b01, 32'hD0);
        chk("t5_err_same", credit_err, 1'b0);
        tick();
        set_credit(1'b0, 2'b00);
        chk("t5_err_set", credit_err, 1'b1);
        tick();
        chk("t5_err_sticky", credit_err, 1'b1);
        do_reset();
        chk("t5_err_clr", credit_err, 1'b0);

        // 6: reset while the body flit is on the output
        set_req(0, 1'b1, 4'd3, 32'hE0);
        tick();
        req_valid = '0;
        tick();
        chk_flit("t6_f0", 1'b1, 1'b0, 2'b01, 32'hE0);
        set_req(0, 1'b0, 4'd3, 32'hE1);
        tick();
        chk_flit("t6_f1", 1'b0, 1'b0, 2'b01, 32'hE1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_fl", flit_valid, 1'b0);
        chk("t6_rst_grant", req_grant, 4'b0000);
        chk("t6_rst_state", state_dbg, 2'd0);
        set_credit(1'b1, 2'b01);
        tick();
        set_credit(1'b0, 2'b00);
        chk("t6_credit_full", credit_err, 1'b1);
        set_req(2, 1'b1, 4'd1, 32'hF2);
        tick();
        chk("t6_grant2", req_grant, 4'b0100);
        req_valid = '0;
        tick();
        chk_flit("t6_f_single", 1'b1, 1'b1, 2'b01, 32'hF2);
        chk("t6_grant_drop", req_grant, 4'b0000);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
